// File: rtl/pucch_lprs_seq_ctrl_pkg.sv
// Shared constants and types for the PUCCH length-12 low-PAPR sequence path.
// Holds the phi code points, the phase modulus and the sequencer state type.
package pucch_pkg;

  localparam int M_ZC   = 12;
  localparam int PH_MOD = 24;

  localparam logic [1:0] PHI_M3 = 2'b10;
  localparam logic [1:0] PHI_M1 = 2'b11;
  localparam logic [1:0] PHI_P1 = 2'b00;
  localparam logic [1:0] PHI_P3 = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } lprs_state_t;

  // 3*phi folded into 0..23 so the phase adder only ever needs one downward wrap.
  function automatic logic [4:0] phi3_mod(input logic [1:0] code);
    logic [4:0] r;
    case (code)
      PHI_M3:  r = 5'(PH_MOD - 9);
      PHI_M1:  r = 5'(PH_MOD - 3);
      PHI_P1:  r = 5'd3;
      default: r = 5'd9;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pucch_lprs_seq_ctrl_varphi12.sv
// Combinational phi(n) lookup for length-12 base sequences, groups u = 0..29.
// Rows are packed with n = 0 in the most significant code slot.
module varphi12
  import pucch_pkg::*;
(
  input  logic [4:0] i_u,
  input  logic [3:0] i_n,
  output logic [1:0] o_phi
);

  localparam logic [1:0] N3 = PHI_M3;
  localparam logic [1:0] N1 = PHI_M1;
  localparam logic [1:0] P1 = PHI_P1;
  localparam logic [1:0] P3 = PHI_P3;

  logic [2*M_ZC-1:0] row;

  always_comb begin
    row   = '0;
    o_phi = P1;
    case (i_u)
      5'd0:  row = {N3,P1,N3,N3,N3,P3,N3,N1,P1,P1,P1,N3};
      5'd1:  row = {N3,P3,P1,N3,P1,P3,N1,N1,P1,P3,P3,P3};
      5'd2:  row = {N3,P3,P3,P1,N3,P3,N1,P1,P3,N3,P3,N3};
      5'd3:  row = {N3,N3,N1,P3,P3,P3,N3,P3,N3,P1,N1,N3};
      5'd4:  row = {N3,N1,N1,P1,P3,P1,P1,N1,P1,N1,N3,P1};
      5'd5:  row = {N3,N3,P3,P1,N3,N3,N3,N1,P3,N1,P1,P3};
      5'd6:  row = {P1,N1,P3,N1,N1,N1,N3,N1,P1,P1,P1,N3};
      5'd7:  row = {N1,N3,P3,N1,N3,N3,N3,N1,P1,N1,P1,N3};
      5'd8:  row = {N3,N1,P3,P1,N3,N1,N3,P3,P1,P3,P3,P1};
      5'd9:  row = {N3,N1,N1,N3,N3,N1,N3,P3,P1,P3,N1,N3};
      5'd10: row = {N3,P3,N3,P3,P3,N3,N1,N1,P3,P3,P1,N3};
      5'd11: row = {N3,N1,N3,N1,N1,N3,P3,P3,N1,N1,P1,N3};
      5'd12: row = {N3,N1,P3,N3,N3,N1,N3,P1,N1,N3,P3,P3};
      5'd13: row = {N3,P1,N1,N1,P3,P3,N3,N1,N1,N3,N1,N3};
      5'd14: row = {P1,P3,N3,P1,P3,P3,P3,P1,N1,P1,N1,P3};
      5'd15: row = {N3,P1,P3,N1,N1,N3,N3,N1,N1,P3,P1,N3};
      5'd16: row = {N1,N1,N1,N1,P1,N3,N1,P3,P3,N1,N3,P1};
      5'd17: row = {N1,P1,P1,N1,P1,P3,P3,N1,N1,N3,P1,N3};
      5'd18: row = {N3,P1,P3,P3,N1,N1,N3,P3,P3,N3,P3,N3};
      5'd19: row = {N3,N3,P3,N3,N1,P3,P3,P3,N1,N3,P1,N3};
      5'd20: row = {P3,P1,P3,P1,P3,N3,N1,P1,P3,P1,N1,N3};
      5'd21: row = {N3,P3,P1,P3,N3,P1,P1,P1,P1,P3,N3,P3};
      5'd22: row = {N3,P3,P3,P3,N1,N3,N3,N1,N3,P1,P3,N3};
      5'd23: row = {P3,N1,N3,P3,N3,N1,P3,P3,P3,N3,N1,N3};
      5'd24: row = {N3,N1,P1,N3,P1,P3,P3,P3,N1,N3,P3,P3};
      5'd25: row = {N3,P3,P1,N1,P3,P3,N3,P1,N1,P1,N1,P1};
      5'd26: row = {N1,P1,P3,N3,P1,N1,P1,N1,N1,N3,P1,N1};
      5'd27: row = {N3,N3,P3,P3,P3,N3,N1,P1,N3,P3,P1,N3};
      5'd28: row = {P1,N1,P3,P1,P1,N1,N1,N1,P1,P3,N3,P1};
      5'd29: row = {N3,P3,N3,P3,N3,N3,P3,N1,N1,P1,P3,N3};
      default: row = '0;
    endcase
    if (i_n < 4'(M_ZC))
      o_phi = row[2*(M_ZC-1-int'(i_n)) +: 2];
  end

endmodule

// File: rtl/pucch_lprs_seq_ctrl.sv
// Length-12 low-PAPR sequence phase sequencer: one request in, twelve phase
// indices (units of pi/12) out through a single backpressured output register.
module pucch_lprs_seq_ctrl #(
  parameter int M_ZC = 12,
  parameter int PH_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req,
  output logic            o_ready,
  input  logic [4:0]      i_u,
  input  logic [3:0]      i_m_cs,
  output logic            o_err,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [PH_W-1:0] o_phase,
  output logic [3:0]      o_n,
  output logic            o_last,
  output logic            o_busy
);
  import pucch_pkg::*;

  lprs_state_t state_q, state_d;

  logic [4:0] u_q;
  logic [3:0] m_q;
  logic [3:0] n_q;
  logic [4:0] acc_q;
  logic       valid_q;
  logic       last_q;
  logic       err_q;
  logic [4:0] phase_q;
  logic [3:0] n_out_q;

  logic       accept, bad_req, load, issue, handoff;
  logic [1:0] phi_code;
  logic [5:0] acc_sum, ph_sum;
  logic [4:0] acc_next, ph_next;

  varphi12 u_varphi12 (
    .i_u   (u_q),
    .i_n   (n_q),
    .o_phi (phi_code)
  );

  assign accept  = i_req && (state_q == IDLE);
  assign bad_req = (i_u > 5'd29) || (i_m_cs > 4'(M_ZC - 1));
  assign load    = !valid_q || i_ready;
  assign issue   = (state_q == RUN) && load;
  assign handoff = valid_q && i_ready && last_q;

  // Both sums stay below 2*24, so one conditional subtract is a full mod-24.
  assign acc_sum  = 6'(acc_q) + 6'({m_q, 1'b0});
  assign acc_next = (acc_sum >= 6'(PH_MOD)) ? 5'(acc_sum - 6'(PH_MOD)) : acc_sum[4:0];
  assign ph_sum   = 6'(acc_q) + 6'(phi3_mod(phi_code));
  assign ph_next  = (ph_sum >= 6'(PH_MOD)) ? 5'(ph_sum - 6'(PH_MOD)) : ph_sum[4:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_busy  = 1'b1;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        o_busy  = 1'b0;
        if (accept && !bad_req) state_d = RUN;
      end
      RUN:   if (issue && (n_q == 4'(M_ZC - 1))) state_d = DRAIN;
      DRAIN: if (handoff) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      u_q     <= '0;
      m_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= '0;
      n_out_q <= '0;
    end else begin
      err_q <= accept && bad_req;
      if (accept) begin
        u_q   <= i_u;
        m_q   <= i_m_cs;
        n_q   <= '0;
        acc_q <= '0;
      end else if (issue) begin
        n_q   <= n_q + 4'd1;
        acc_q <= acc_next;
      end
      if (issue) begin
        valid_q <= 1'b1;
        phase_q <= ph_next;
        n_out_q <= n_q;
        last_q  <= (n_q == 4'(M_ZC - 1));
      end else if (valid_q && i_ready) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_phase = PH_W'(phase_q);
  assign o_n     = n_out_q;
  assign o_last  = last_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_pucch_lprs_seq_ctrl.sv
// Directed self-checking bench for pucch_lprs_seq_ctrl using hand-computed
// phase tables for group u = 0 with m_cs = 0 and m_cs = 1.
module tb_pucch_lprs_seq_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_req = 1'b0;
  logic       o_ready;
  logic [4:0] i_u = '0;
  logic [3:0] i_m_cs = '0;
  logic       o_err;
  logic       o_valid;
  logic       i_ready = 1'b1;
  logic [4:0] o_phase;
  logic [3:0] o_n;
  logic       o_last;
  logic       o_busy;

  int checks = 0;
  int errors = 0;

  int exp_m0 [12] = '{15, 3, 15, 15, 15, 9, 15, 21, 3, 3, 3, 15};
  int exp_m1 [12] = '{15, 5, 19, 21, 23, 19, 3, 11, 19, 21, 23, 13};

  always #5 i_clk = ~i_clk;

  pucch_lprs_seq_ctrl #(.M_ZC(12), .PH_W(5)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_req),
    .o_ready (o_ready),
    .i_u     (i_u),
    .i_m_cs  (i_m_cs),
    .o_err   (o_err),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_phase (o_phase),
    .o_n     (o_n),
    .o_last  (o_last),
    .o_busy  (o_busy)
  );

  function automatic int exp_phase(input int m, input int i);
    return (m == 0) ? exp_m0[i] : exp_m1[i];
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0 || o_phase !== 5'd0 || o_n !== 4'd0 || o_last !== 1'b0 ||
        o_err !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b phase=%0d n=%0d last=%b err=%b busy=%b ready=%b expected 0,0,0,0,0,0,1",
               o_valid, o_phase, o_n, o_last, o_err, o_busy, o_ready);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b expected 1 0", o_ready, o_valid);
    end
    $display("reset done");
  endtask

  // Called just after a negedge; returns just after the negedge following the accept edge.
  task automatic accept(input logic [4:0] u, input logic [3:0] m);
    i_u = u; i_m_cs = m; i_req = 1'b1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: ready=%b expected 1", o_ready);
    end
    @(negedge i_clk);
    i_req = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_latency: valid=%b busy=%b expected 0 1", o_valid, o_busy);
    end
  endtask

  task automatic run_samples(input int m);
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b1 || o_n !== 4'(i)) begin
        errors++;
        $display("FAIL sample_n m=%0d: valid=%b n=%0d expected valid=1 n=%0d", m, o_valid, o_n, i);
      end
      checks++;
      if (o_phase !== 5'(exp_phase(m, i))) begin
        errors++;
        $display("FAIL sample_phase m=%0d n=%0d: got %0d expected %0d", m, i, o_phase, exp_phase(m, i));
      end
      checks++;
      if (o_last !== logic'(i == 11)) begin
        errors++;
        $display("FAIL sample_last m=%0d n=%0d: got %b expected %b", m, i, o_last, (i == 11));
      end
    end
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL seq_end m=%0d: valid=%b ready=%b busy=%b expected 0 1 0", m, o_valid, o_ready, o_busy);
    end
    $display("seq u=0 m_cs=%0d done", m);
  endtask

  task automatic test_basic(input int m);
    i_ready = 1'b1;
    accept(5'd0, 4'(m));
    run_samples(m);
  endtask

  task automatic test_backpressure();
    int   idx = 0;
    int   cyc = 0;
    logic stalled = 1'b0;
    logic rdy;
    logic [4:0] prev_ph = '0;
    logic [3:0] prev_n = '0;
    logic       prev_last = 1'b0;
    accept(5'd0, 4'd0);
    while (idx < 12 && cyc < 400) begin
      @(negedge i_clk);
      cyc++;
      if (stalled) begin
        checks++;
        if (o_valid !== 1'b1 || o_phase !== prev_ph || o_n !== prev_n || o_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: valid=%b phase=%0d n=%0d last=%b expected 1 %0d %0d %b",
                   o_valid, o_phase, o_n, o_last, prev_ph, prev_n, prev_last);
        end
      end
      if (o_valid === 1'b1) begin
        checks++;
        if (o_n !== 4'(idx) || o_phase !== 5'(exp_m0[idx]) || o_last !== logic'(idx == 11)) begin
          errors++;
          $display("FAIL bp_sample idx=%0d: n=%0d phase=%0d last=%b expected %0d %0d %b",
                   idx, o_n, o_phase, o_last, idx, exp_m0[idx], (idx == 11));
        end
      end
      rdy = logic'($urandom_range(0, 1));
      i_ready = rdy;
      stalled = (o_valid === 1'b1) && !rdy;
      prev_ph = o_phase; prev_n = o_n; prev_last = o_last;
      if (o_valid === 1'b1 && rdy) idx++;
    end
    checks++;
    if (idx != 12) begin
      errors++;
      $display("FAIL bp_timeout: handed off %0d samples expected 12", idx);
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: ready=%b valid=%b expected 1 0", o_ready, o_valid);
    end
    $display("seq backpressure done after %0d cycles", cyc);
  endtask

  task automatic test_drain_hold();
    i_ready = 1'b1;
    accept(5'd0, 4'd0);
    repeat (12) @(negedge i_clk);
    i_ready = 1'b0;
    repeat (4) begin
      @(negedge i_clk);
      checks++;
      if (o_valid !== 1'b1 || o_last !== 1'b1 || o_n !== 4'd11 || o_phase !== 5'd15 ||
          o_ready !== 1'b0 || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL drain_hold: valid=%b last=%b n=%0d phase=%0d ready=%b busy=%b expected 1 1 11 15 0 1",
                 o_valid, o_last, o_n, o_phase, o_ready, o_busy);
      end
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_release: ready=%b valid=%b expected 1 0", o_ready, o_valid);
    end
    $display("seq drain hold done");
  endtask

  task automatic test_err(input logic [4:0] u, input logic [3:0] m);
    i_u = u; i_m_cs = m; i_req = 1'b1;
    @(negedge i_clk);
    i_req = 1'b0;
    checks++;
    if (o_err !== 1'b1 || o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse u=%0d m=%0d: err=%b ready=%b valid=%b busy=%b expected 1 1 0 0",
               u, m, o_err, o_ready, o_valid, o_busy);
    end
    repeat (3) begin
      @(negedge i_clk);
      checks++;
      if (o_err !== 1'b0 || o_valid !== 1'b0 || o_ready !== 1'b1) begin
        errors++;
        $display("FAIL err_after u=%0d m=%0d: err=%b valid=%b ready=%b expected 0 0 1",
                 u, m, o_err, o_valid, o_ready);
      end
    end
    $display("bad request u=%0d m_cs=%0d rejected", u, m);
  endtask

  task automatic test_busy_req();
    i_ready = 1'b1;
    accept(5'd0, 4'd1);
    i_u = 5'd0; i_m_cs = 4'd0; i_req = 1'b1;
    run_samples(1);
    @(negedge i_clk);
    i_req = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_req_accept: busy=%b valid=%b expected 1 0", o_busy, o_valid);
    end
    run_samples(0);
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b1;
    accept(5'd0, 4'd0);
    repeat (6) @(negedge i_clk);
    checks++;
    if (o_n !== 4'd5) begin
      errors++;
      $display("FAIL reset_mid_pos: n=%0d expected 5", o_n);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_phase !== 5'd0 || o_n !== 4'd0 || o_last !== 1'b0 ||
        o_err !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: valid=%b phase=%0d n=%0d last=%b err=%b busy=%b ready=%b expected 0,0,0,0,0,0,1",
               o_valid, o_phase, o_n, o_last, o_err, o_busy, o_ready);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    accept(5'd0, 4'd1);
    run_samples(1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic(0);
    test_basic(1);
    test_backpressure();
    test_drain_hold();
    test_err(5'd30, 4'd0);
    test_err(5'd0, 4'd12);
    test_busy_req();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pucch_lprs_seq_ctrl.md
# pucch_lprs_seq_ctrl

Sequencer for the length-12 low-PAPR base sequence used by PUCCH formats 0/1. Accepts one request (group u, cyclic shift m_cs), walks n = 0..11 through the existing `varphi12` lookup, and emits one phase index per cycle. Each phase index is the phase of r(n) = e^{j(αn + φ(n)π/4)} in units of π/12. The block sits between the PUCCH symbol scheduler and the phase-to-IQ ROM / RE mapper, with valid/ready backpressure on the output.

## Interface
- Parameters:
- `M_ZC`, 12: sequence length; fixed, and the only supported value.
- `PH_W`, 5: phase index width; range 0..23, in units of π/12.
- Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `i_req`  in  1  request valid.
- `o_ready`  out  1  request ready; high only in IDLE.
- `i_u`  in  5  sequence group, 0..29.
- `i_m_cs`  in  4  cyclic shift index, 0..11; α = 2π·m_cs/12.
- `o_err`  out  1  one-cycle pulse when an out-of-range request is accepted.
- `o_valid`  out  1  output sample valid.
- `i_ready`  in  1  downstream ready.
- `o_phase`  out  PH_W  (3·φ(n) + 2·m_cs·n) mod 24.
- `o_n`  out  4  sample index n.
- `o_last`  out  1  high with n = 11.
- `o_busy`  out  1  high when state ≠ IDLE.

## Operation
- Handshake and request capture:
  - A request is accepted on any edge where `i_req & o_ready`.
  - u and m_cs are latched in registers `u_q` and `m_q`.
- Range check: if u > 29 or m_cs > 11:
  - `o_err` pulses for one cycle.
  - No samples are produced and the state stays IDLE.
- State machine:
  - IDLE → RUN on a valid accept.
  - RUN: counter `n_q` drives `varphi12.i_n`; `u_q` drives `i_u`.
  - RUN → DRAIN after the lookup for n = 11 is issued.
  - DRAIN → IDLE when the n = 11 sample is handed off (`o_valid & i_ready & o_last`).
- φ decode from the 2-bit code: 10 → −3, 11 → −1, 00 → +1, 01 → +3.
- No multiplier is used. Phase is computed with an accumulator `acc_q` (0..23):
  - `acc_q` resets to 0 at accept.
  - It adds 2·m_cs mod 24 per advance of n, with wrap by conditional subtract of 24.
  - o_phase = (acc_q + 3φ) mod 24.
  - 3φ ∈ {−9, −3, 3, 9}; the sum range −9..32 is corrected by ±24.
- Output register stage:
  - The stage loads when empty or when `i_ready` is high.
  - `n_q` and `acc_q` advance only when the stage loads.
  - While `o_valid & !i_ready`, `o_phase`, `o_n` and `o_last` are held stable.

## Timing
- Reset values: all of the following are 0, except `o_ready`, which is 1.
  - Outputs: `o_valid`, `o_phase`, `o_n`, `o_last`, `o_err`, `o_busy`.
  - Internal: `n_q`, `acc_q`, `u_q`, `m_q`.
  - State: IDLE.
- Latency and throughput:
  - With an accept at edge k, `o_valid` is high after edge k+1 with n = 0.
  - With `i_ready` held high, n = 11 is presented after edge k+12.
  - `o_ready` returns high after the handoff edge of n = 11.
  - The minimum request-to-request spacing is 13 cycles.
- `o_err` is high for exactly the cycle after the bad accept edge.
- `i_req` while busy: ignored, with no effect on the current sequence.
- Reset mid-sequence: asynchronously clears the state. There is no partial continuation and no `o_last`.
- Backpressure at n = 11 holds DRAIN indefinitely; `o_ready` stays low.

## Structure
- Shared package `pucch_pkg` contains:
  - `M_ZC`.
  - The φ code localparams (10/11/00/01).
  - The phase modulus 24.
  - The state enum typedef `lprs_state_t` {IDLE, RUN, DRAIN}.
- The existing `varphi12` is instantiated as the only sub-module; its lookup is combinational.
- Everything else is local: the counter, the accumulator, the mod-24 adders and the output register.

## Test plan
- u=0, m_cs=0, `i_ready`=1 → phases 15,3,15,15,15,9,15,21,3,3,3,15 at n=0..11; `o_last` only at n=11; first `o_valid` one cycle after accept.
- u=0, m_cs=1 → phases (3φ+2n) mod 24: 15,5,19,21,23,19,3,11,19,21,23,13.
- u=0, m_cs=0, with `i_ready` toggled pseudo-randomly → same 12 values in order, with outputs stable during every stall.
- u=30 or m_cs=12 → one-cycle `o_err`, no `o_valid`, `o_ready` high the next cycle.
- Assert `i_req` with new u/m_cs while busy → ignored, and the current sequence is unchanged; after `o_last`, `o_ready` rises and the new request is accepted.
- Assert `i_rst_n` low at n=5 → all outputs at reset values immediately; after release, a fresh request starts at n=0 with `acc_q`=0.
